write_register_16_bit: RTL and testbench

- Write side of the 16 x 16-bit register file; owns the register storage and feeds the combinational read mux through a flat bus.
- Accepts single-word writes over a valid/ready handshake, with one-hot decode of a 4-bit address.
- Provides a sequenced clear that zeros all registers one per cycle.
- Sits between the writeback stage and the register read mux in the microprocessor datapath.

---
 rtl/write_register_16_bit.sv | 128 ++++++++++++
 tb/tb_write_register_16_bit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/write_register_16_bit.sv
// rtl/write_register_16_bit.sv - write side of the 16 x 16-bit register file with sequenced clear
//
// Owns the register storage and presents it on a flat bus to the read mux.
// Single-word writes use a valid/ready handshake; a clear request zeros one
// register per cycle, starting at index 0, over DEPTH cycles.
//
// Optional feature macro: R0_ZERO_EN
//   defined   -> register 0 is hardwired to 0; writes to address 0 are acked
//                but their data is discarded
//   undefined -> register 0 is an ordinary writable register
//
// Ports:
//   clk            system clock, rising-edge active
//   rst_n          asynchronous active-low reset
//   wr_valid       write request valid
//   wr_ready       write can be accepted this cycle
//   wr_addr        destination register index
//   wr_data        data to write
//   wr_ack         one-cycle pulse the cycle after an accepted write
//   clr_req        request to clear all registers
//   busy           clear sequence in progress
//   clr_done       one-cycle pulse after the last register is cleared
//   registers_flat register i on bits [i*WIDTH +: WIDTH]

module write_register_16_bit #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_ack,
    input  logic                   clr_req,
    output logic                   busy,
    output logic                   clr_done,
    output logic [WIDTH*DEPTH-1:0] registers_flat
);

`ifdef R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_next;
    logic              wr_en;
    logic              clr_last;

    logic [WIDTH-1:0]  regs [DEPTH];

    // clr_req blocks writes combinationally so a simultaneous write is never
    // acknowledged once the clear has been chosen.
    assign wr_ready = (state == IDLE) && !clr_req;
    assign busy     = (state == CLEAR);
    assign clr_last = (state == CLEAR) && (cnt == LAST_IDX);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end else if (wr_valid) begin
                    wr_en = 1'b1;
                end
            end
            CLEAR: begin
                // Counter wraps back to 0 on the final step.
                cnt_next = cnt + 1'b1;
                if (cnt == LAST_IDX) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_ack   <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            wr_ack   <= wr_en;
            clr_done <= clr_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_en && !(R0_ZERO && (wr_addr == '0))) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign registers_flat[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_write_register_16_bit.sv
// tb/tb_write_register_16_bit.sv - self-checking bench for write_register_16_bit

module tb_write_register_16_bit;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int ADDR_W = 4;

`ifdef R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   wr_valid = 1'b0;
    logic                   wr_ready;
    logic [ADDR_W-1:0]      wr_addr = '0;
    logic [WIDTH-1:0]       wr_data = '0;
    logic                   wr_ack;
    logic                   clr_req = 1'b0;
    logic                   busy;
    logic                   clr_done;
    logic [WIDTH*DEPTH-1:0] registers_flat;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;

    // Behavioural model: register contents plus remaining clear steps.
    logic [WIDTH-1:0] m_regs [DEPTH];
    int               m_clear_left = 0;
    logic             m_ack = 1'b0;
    logic             m_done = 1'b0;

    write_register_16_bit #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .clr_req(clr_req),
        .busy(busy), .clr_done(clr_done), .registers_flat(registers_flat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH*DEPTH-1:0] model_flat();
        logic [WIDTH*DEPTH-1:0] f;
        for (int i = 0; i < DEPTH; i++) f[i*WIDTH +: WIDTH] = m_regs[i];
        return f;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) m_regs[i] = '0;
                m_clear_left = 0;
                m_ack = 1'b0;
                m_done = 1'b0;
            end else begin
                m_ack = 1'b0;
                m_done = 1'b0;
                if (m_clear_left > 0) begin
                    m_regs[DEPTH - m_clear_left] = '0;
                    m_clear_left--;
                    if (m_clear_left == 0) m_done = 1'b1;
                end else if (clr_req) begin
                    m_clear_left = DEPTH;
                end else if (wr_valid) begin
                    if (!(R0Z && wr_addr == 0)) m_regs[wr_addr] = wr_data;
                    m_ack = 1'b1;
                end
            end
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_wr_ready", 256'(wr_ready), 256'((m_clear_left == 0) && !clr_req));
            chk("cyc_busy", 256'(busy), 256'(m_clear_left > 0));
            chk("cyc_wr_ack", 256'(wr_ack), 256'(m_ack));
            chk("cyc_clr_done", 256'(clr_done), 256'(m_done));
            chk("cyc_flat", 256'(registers_flat), 256'(model_flat()));
            if (clr_done) done_seen++;
        end
    end

    task automatic drive(input logic v, input logic [3:0] a, input logic [15:0] d, input logic c);
        @(negedge clk);
        #2;
        wr_valid = v;
        wr_addr  = a;
        wr_data  = d;
        clr_req  = c;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int done_before;
        logic [15:0] exp16;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_wr_ready", 256'(wr_ready), 256'(1));
        chk("rst_flat_zero", 256'(registers_flat), 256'(0));

        // Single write, addr 3
        drive(1'b1, 4'd3, 16'hBEEF, 1'b0);
        drive(1'b0, 4'd0, 16'h0, 1'b0);
        chk("beef_slice", 256'(registers_flat[63:48]), 256'(16'hBEEF));
        chk("beef_flat", 256'(registers_flat), 256'(256'hBEEF) << 48);
        chk("beef_ack", 256'(wr_ack), 256'(1));
        drive(1'b0, 4'd0, 16'h0, 1'b0);
        chk("beef_ack_drop", 256'(wr_ack), 256'(0));

        // Fill all registers back-to-back
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0);
            #1 chk("fill_ready", 256'(wr_ready), 256'(1));
        end
        drive(1'b0, 4'd0, 16'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            exp16 = (R0Z && i == 0) ? 16'h0 : 16'h1000 + 16'(i);
            chk("fill_slice", 256'(registers_flat[i*WIDTH +: WIDTH]), 256'(exp16));
        end

        // Clear with a simultaneous write that must be dropped
        drive(1'b1, 4'd5, 16'h5555, 1'b1);
        #1 chk("clr_blocks_write", 256'(wr_ready), 256'(0));
        busy_cnt = 0;
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            drive(1'b0, 4'd0, 16'h0, 1'b0);
            if (busy) busy_cnt++;
            if (clr_done) done_cnt++;
            chk("clr_done_timing", 256'(clr_done), 256'(n == DEPTH));
            for (int k = 0; k < DEPTH; k++) begin
                exp16 = (k < n || (R0Z && k == 0)) ? 16'h0 : 16'h1000 + 16'(k);
                chk("clr_slice", 256'(registers_flat[k*WIDTH +: WIDTH]), 256'(exp16));
            end
        end
        chk("clr_busy_cycles", 256'(busy_cnt), 256'(16));
        chk("clr_done_count", 256'(done_cnt), 256'(1));
        chk("clr_flat_zero", 256'(registers_flat), 256'(0));

        // Reset during CLEAR
        drive(1'b1, 4'd2, 16'h1234, 1'b0);
        drive(1'b1, 4'd7, 16'h7777, 1'b0);
        drive(1'b1, 4'd15, 16'hFFFF, 1'b0);
        drive(1'b0, 4'd0, 16'h0, 1'b1);
        repeat (7) drive(1'b0, 4'd0, 16'h0, 1'b0);
        chk("midclr_busy_before", 256'(busy), 256'(1));
        chk("midclr_r15_kept", 256'(registers_flat[255:240]), 256'(16'hFFFF));
        done_before = done_seen;
        rst_n = 1'b0;
        #1;
        chk("midclr_flat_zero", 256'(registers_flat), 256'(0));
        chk("midclr_busy", 256'(busy), 256'(0));
        chk("midclr_done", 256'(clr_done), 256'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("midclr_ready", 256'(wr_ready), 256'(1));
        repeat (20) drive(1'b0, 4'd0, 16'h0, 1'b0);
        chk("midclr_no_done", 256'(done_seen - done_before), 256'(0));

        // Same address twice in consecutive cycles
        drive(1'b1, 4'd9, 16'hAAAA, 1'b0);
        drive(1'b1, 4'd9, 16'h0F0F, 1'b0);
        chk("dbl_first", 256'(registers_flat[159:144]), 256'(16'hAAAA));
        chk("dbl_ack1", 256'(wr_ack), 256'(1));
        drive(1'b0, 4'd0, 16'h0, 1'b0);
        chk("dbl_second", 256'(registers_flat[159:144]), 256'(16'h0F0F));
        chk("dbl_ack2", 256'(wr_ack), 256'(1));
        drive(1'b0, 4'd0, 16'h0, 1'b0);
        chk("dbl_ack_drop", 256'(wr_ack), 256'(0));

        // Register 0 write
        drive(1'b1, 4'd0, 16'hFFFF, 1'b0);
        drive(1'b0, 4'd0, 16'h0, 1'b0);
        chk("r0_ack", 256'(wr_ack), 256'(1));
        chk("r0_slice", 256'(registers_flat[15:0]), R0Z ? 256'(0) : 256'(16'hFFFF));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  16'($urandom), ($urandom_range(0, 24) == 0));
        end
        repeat (DEPTH + 2) drive(1'b0, 4'd0, 16'h0, 1'b0);

        @(negedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
